// File: rtl/c5efa7_bts_sysid_checker.sv
// c5efa7_bts_sysid_checker: reads the ID and timestamp words from a sysid slave and compares them with expected values
// Ports: clock/reset (sync, active-high), start (one-cycle launch request),
// avm_address/avm_read/avm_readdata/avm_waitrequest (Avalon-MM read master),
// busy/done/pass plus sticky id_mismatch/ts_mismatch/timeout, id_value/ts_value (captured words).
module c5efa7_bts_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1360724818,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit AUTO_START = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;
    state_t state;
    logic [15:0] cnt;
    logic auto_arm;
    logic launch;
    logic expire;
    logic id_bad;
    logic ts_bad;
    // auto_arm is only ever set by reset, so it can fire from IDLE alone and only once per release
    assign launch = (state == IDLE || state == DONE) && (start || auto_arm);
    assign expire = 17'(cnt) + 17'd1 == 17'(TIMEOUT_CYCLES);
    assign id_bad = avm_readdata != EXPECTED_ID;
    assign ts_bad = avm_readdata != EXPECTED_TS;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            auto_arm <= AUTO_START;
            avm_address <= 1'b0;
            avm_read <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            auto_arm <= 1'b0;
            if (launch) begin
                state <= RD_ID;
                cnt <= '0;
                avm_address <= 1'b0;
                avm_read <= 1'b1;
                busy <= 1'b1;
                done <= 1'b0;
                pass <= 1'b0;
                id_mismatch <= 1'b0;
                ts_mismatch <= 1'b0;
                timeout <= 1'b0;
            end else if (state == RD_ID || state == RD_TS) begin
                if (avm_waitrequest) begin
                    cnt <= cnt + 16'd1;
                    if (expire) begin
                        state <= DONE;
                        avm_read <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= 1'b0;
                        timeout <= 1'b1;
                    end
                end else if (state == RD_ID) begin
                    state <= RD_TS;
                    cnt <= '0;
                    id_value <= avm_readdata;
                    id_mismatch <= id_bad;
                    avm_address <= 1'b1;
                end else begin
                    state <= DONE;
                    ts_value <= avm_readdata;
                    ts_mismatch <= ts_bad;
                    avm_read <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b1;
                    // id_mismatch was settled on the earlier RD_ID edge; ts uses this edge's compare
                    pass <= !(id_mismatch || ts_bad);
                end
            end
        end
    end
endmodule

// File: tb/tb_c5efa7_bts_sysid_checker.sv
// tb_c5efa7_bts_sysid_checker: directed table-driven bench for the sysid checker
module tb_c5efa7_bts_sysid_checker;
    localparam logic [31:0] TS = 32'd1360724818;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic avm_address;
    logic avm_read;
    logic [31:0] avm_readdata;
    logic avm_waitrequest = 1'b0;
    logic busy;
    logic done;
    logic pass;
    logic id_mismatch;
    logic ts_mismatch;
    logic timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [31:0] id_word = 32'd0;
    logic [31:0] ts_word = TS;
    int id_left = 0;
    int ts_left = 0;
    logic wr_addr = 1'b0;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [31:0] id_w;
        logic [31:0] ts_w;
        int id_s;
        int ts_s;
        logic pass;
        logic idm;
        logic tsm;
        logic to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int lat;
    } vec_t;
    vec_t vt[10];
    c5efa7_bts_sysid_checker #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b1)) dut (
        .clock(clk),
        .reset(reset),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy),
        .done(done),
        .pass(pass),
        .id_mismatch(id_mismatch),
        .ts_mismatch(ts_mismatch),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );
    always #5 clk = ~clk;
    assign avm_readdata = avm_address ? ts_word : id_word;
    // slave model: stalls the current address for the requested number of edges
    always @(posedge clk) begin
        #2;
        if (avm_waitrequest) begin
            if (wr_addr && ts_left > 0) ts_left = ts_left - 1;
            if (!wr_addr && id_left > 0) id_left = id_left - 1;
        end
        avm_waitrequest = avm_read && (avm_address ? ts_left > 0 : id_left > 0);
        wr_addr = avm_address;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    // counts edges from the launch edge to the done edge, read-high cycles and stall-stability breaks
    task automatic wait_done(output int lat, output int rd, output int unstable);
        logic pa;
        logic pr;
        logic pw;
        lat = 0;
        rd = 0;
        unstable = 0;
        while (!done && lat < 100) begin
            pa = avm_address;
            pr = avm_read;
            pw = avm_waitrequest;
            rd += int'(avm_read);
            @(negedge clk);
            lat++;
            if (pw && pr && !done && (avm_address != pa || !avm_read)) unstable++;
        end
    endtask
    initial begin
        int lat;
        int rd;
        int un;
        vt[0] = '{32'd0, TS, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, TS, 2};
        vt[1] = '{32'd0, 32'h12345678, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h12345678, 2};
        vt[2] = '{32'd0, TS, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, TS, 5};
        vt[3] = '{32'd5, TS, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5, TS, 2};
        vt[4] = '{32'd0, TS, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, TS, 9};
        vt[5] = '{32'd0, TS, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, TS, 8};
        vt[6] = '{32'd0, TS, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, TS, 4};
        vt[7] = '{32'hAA, 32'hBB, 0, 1000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAA, TS, 9};
        vt[8] = '{32'd1, 32'd2, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 32'd2, 2};
        vt[9] = '{32'd0, TS, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, TS, 2};
        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({busy, done, pass, id_mismatch, ts_mismatch, timeout, avm_read, avm_address}), 32'd0);
        chk("reset_id", id_value, 32'd0);
        chk("reset_ts", ts_value, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("auto_launch", 32'({busy, avm_read, avm_address, done}), 32'b1100);
        @(negedge clk);
        chk("auto_rd_ts", 32'({busy, avm_read, avm_address, done}), 32'b1110);
        @(negedge clk);
        chk("auto_done", 32'({busy, avm_read, done, pass}), 32'b0011);
        chk("auto_id", id_value, 32'd0);
        chk("auto_ts", ts_value, TS);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_word = vt[i].id_w;
            ts_word = vt[i].ts_w;
            id_left = vt[i].id_s;
            ts_left = vt[i].ts_s;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(lat, rd, un);
            chk($sformatf("v%0d_flags", i), 32'({done, pass, id_mismatch, ts_mismatch, timeout, busy, avm_read}),
                32'({1'b1, vt[i].pass, vt[i].idm, vt[i].tsm, vt[i].to, 1'b0, 1'b0}));
            chk($sformatf("v%0d_id_value", i), id_value, vt[i].idv);
            chk($sformatf("v%0d_ts_value", i), ts_value, vt[i].tsv);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_read_cycles", i), 32'(rd), 32'(vt[i].lat));
            chk($sformatf("v%0d_stall_stable", i), 32'(un), 32'd0);
        end
        // start held over the first three edges of a stalled check must not restart it
        id_word = 32'd0;
        ts_word = TS;
        id_left = 3;
        ts_left = 0;
        start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 2) start = 1'b0;
        end
        chk("busy_start_latency", 32'(lat), 32'd5);
        repeat (4) @(negedge clk);
        chk("busy_start_hold", 32'({done, busy, pass, avm_read}), 32'b1010);
        // reset in RD_TS, then automatic relaunch after release
        ts_left = 1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_in_rd_ts", 32'({busy, avm_read, avm_address}), 32'b111);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_flags", 32'({avm_read, busy, done, pass, avm_address, timeout}), 32'd0);
        chk("mid_reset_id", id_value, 32'd0);
        chk("mid_reset_ts", ts_value, 32'd0);
        reset = 1'b0;
        ts_left = 0;
        id_left = 0;
        @(negedge clk);
        chk("relaunch_busy", 32'({busy, avm_read, done}), 32'b110);
        repeat (2) @(negedge clk);
        chk("relaunch_done", 32'({done, pass, busy, timeout}), 32'b1100);
        repeat (6) @(negedge clk);
        chk("done_hold", 32'({done, pass, busy, avm_read, id_mismatch, ts_mismatch}), 32'b110000);
        chk("done_hold_ts", ts_value, TS);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
